// File: rtl/load_store_sequencer.sv
// RV64 load/store sequencer: splits an access into one or two doubleword beats,
// lane-aligns store data/strobes and right-justifies load data for write-back.
module load_store_sequencer #(
  parameter bit          ALLOW_SPLIT    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [2:0]  sel_mem_extension,
  output logic [63:0] mem_value
);

  localparam int unsigned   CNT_W   = 32;
  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_is_store;
  logic [2:0]         r_funct3;
  logic [63:0]        r_addr;
  logic [63:0]        r_wdata;
  logic [63:0]        r_rdata0;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_req_ready;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [63:0]        r_mem_addr;
  logic [63:0]        r_mem_wdata;
  logic [7:0]         r_mem_wstrb;
  logic               r_resp_valid;
  logic               r_resp_err;
  logic [2:0]         r_sel;
  logic [63:0]        r_mem_value;

  // In IDLE the live request is decoded so the first beat is registered at accept.
  logic               w_idle;
  logic               w_is_store;
  logic [2:0]         w_funct3;
  logic [63:0]        w_addr;
  logic [63:0]        w_wdata;
  logic [2:0]         w_off;
  logic [3:0]         w_size;
  logic               w_cross;
  logic               w_illegal;
  logic [7:0]         w_bmask;
  logic [63:0]        w_vmask;
  logic [15:0]        w_strb16;
  logic [5:0]         w_sh;
  logic [127:0]       w_wdata128;
  logic [63:0]        w_rd0;
  logic [63:0]        w_rd1;
  logic [63:0]        w_ldval;
  logic [2:0]         w_sel;
  logic [63:0]        w_base;

  assign w_idle     = (r_state == S_IDLE);
  assign w_is_store = w_idle ? req_is_store : r_is_store;
  assign w_funct3   = w_idle ? req_funct3   : r_funct3;
  assign w_addr     = w_idle ? req_addr     : r_addr;
  assign w_wdata    = w_idle ? req_wdata    : r_wdata;

  assign w_off      = w_addr[2:0];
  assign w_size     = 4'd1 << w_funct3[1:0];
  assign w_cross    = (({1'b0, w_off} + w_size) > 4'd8);
  assign w_illegal  = (w_is_store ? w_funct3[2] : (w_funct3 == 3'b111)) | (w_cross & !ALLOW_SPLIT);
  assign w_base     = {w_addr[63:3], 3'b000};

  always_comb begin
    w_bmask = 8'h01;
    w_vmask = 64'h0000_0000_0000_00FF;
    case (w_funct3[1:0])
      2'd1:    begin w_bmask = 8'h03; w_vmask = 64'h0000_0000_0000_FFFF; end
      2'd2:    begin w_bmask = 8'h0F; w_vmask = 64'h0000_0000_FFFF_FFFF; end
      2'd3:    begin w_bmask = 8'hFF; w_vmask = 64'hFFFF_FFFF_FFFF_FFFF; end
      default: begin w_bmask = 8'h01; w_vmask = 64'h0000_0000_0000_00FF; end
    endcase
  end

  // Low half of each 128-bit shift belongs to beat0, high half to beat1.
  assign w_strb16   = {8'h00, w_bmask} << w_off;
  assign w_sh       = {w_off, 3'b000};
  assign w_wdata128 = {64'h0, w_wdata} << w_sh;
  assign w_rd0      = (r_state == S_BEAT1) ? r_rdata0  : mem_rdata;
  assign w_rd1      = (r_state == S_BEAT1) ? mem_rdata : 64'h0;
  assign w_ldval    = 64'({w_rd1, w_rd0} >> w_sh) & w_vmask;
  assign w_sel      = {w_funct3[1:0], w_funct3[2]};

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_timeout;
  logic               w_req_ready_nxt;
  logic               w_mem_req_nxt;
  logic               w_mem_we_nxt;
  logic [63:0]        w_mem_addr_nxt;
  logic [63:0]        w_mem_wdata_nxt;
  logic [7:0]         w_mem_wstrb_nxt;
  logic               w_resp_valid_nxt;
  logic               w_resp_err_nxt;
  logic [2:0]         w_sel_nxt;
  logic [63:0]        w_mem_value_nxt;

  // Next state plus the registered output values for that state.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_timeout        = 1'b0;
    w_req_ready_nxt  = 1'b0;
    w_mem_req_nxt    = 1'b0;
    w_mem_we_nxt     = 1'b0;
    w_mem_addr_nxt   = 64'h0;
    w_mem_wdata_nxt  = 64'h0;
    w_mem_wstrb_nxt  = 8'h00;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = 1'b0;
    w_sel_nxt        = 3'b000;
    w_mem_value_nxt  = 64'h0;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = w_illegal ? S_RESP : S_BEAT0;
          w_cnt_nxt   = '0;
        end
      end
      S_BEAT0, S_BEAT1: begin
        if (mem_ack) begin
          w_state_nxt = ((r_state == S_BEAT0) && w_cross) ? S_BEAT1 : S_RESP;
          w_cnt_nxt   = '0;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_state_nxt = S_RESP;
          w_timeout   = 1'b1;
        end else if (TO_EN) begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_IDLE: w_req_ready_nxt = 1'b1;
      S_BEAT0: begin
        w_mem_req_nxt   = 1'b1;
        w_mem_we_nxt    = w_is_store;
        w_mem_addr_nxt  = w_base;
        w_mem_wstrb_nxt = w_is_store ? w_strb16[7:0]     : 8'h00;
        w_mem_wdata_nxt = w_is_store ? w_wdata128[63:0]  : 64'h0;
      end
      S_BEAT1: begin
        w_mem_req_nxt   = 1'b1;
        w_mem_we_nxt    = w_is_store;
        w_mem_addr_nxt  = w_base + 64'd8;
        w_mem_wstrb_nxt = w_is_store ? w_strb16[15:8]    : 8'h00;
        w_mem_wdata_nxt = w_is_store ? w_wdata128[127:64] : 64'h0;
      end
      S_RESP: begin
        w_resp_valid_nxt = 1'b1;
        w_resp_err_nxt   = w_timeout | (w_idle & w_illegal);
        if (!w_resp_err_nxt && !w_is_store) begin
          w_sel_nxt       = w_sel;
          w_mem_value_nxt = w_ldval;
        end
      end
      default: w_req_ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= 64'h0;
      r_wdata      <= 64'h0;
      r_rdata0     <= 64'h0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 64'h0;
      r_mem_wdata  <= 64'h0;
      r_mem_wstrb  <= 8'h00;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_sel        <= 3'b000;
      r_mem_value  <= 64'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_sel        <= w_sel_nxt;
      r_mem_value  <= w_mem_value_nxt;
      if (w_idle && req_valid) begin
        r_is_store <= req_is_store;
        r_funct3   <= req_funct3;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
      end
      if ((r_state == S_BEAT0) && mem_ack) begin
        r_rdata0 <= mem_rdata;
      end
    end
  end

  assign req_ready         = r_req_ready;
  assign mem_req           = r_mem_req;
  assign mem_we            = r_mem_we;
  assign mem_addr          = r_mem_addr;
  assign mem_wdata         = r_mem_wdata;
  assign mem_wstrb         = r_mem_wstrb;
  assign resp_valid        = r_resp_valid;
  assign resp_err          = r_resp_err;
  assign sel_mem_extension = r_sel;
  assign mem_value         = r_mem_value;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer: a split-capable instance and a no-split,
// 4-cycle-timeout instance, checked against a byte-level reference model.
module tb_load_store_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_a, req_valid_b;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        mem_ack_a, mem_ack_b;
  logic [63:0] mem_rdata;

  logic        a_req_ready, a_mem_req, a_mem_we, a_resp_valid, a_resp_err;
  logic [63:0] a_mem_addr, a_mem_wdata, a_mem_value;
  logic [7:0]  a_mem_wstrb;
  logic [2:0]  a_sel;
  logic        b_req_ready, b_mem_req, b_mem_we, b_resp_valid, b_resp_err;
  logic [63:0] b_mem_addr, b_mem_wdata, b_mem_value;
  logic [7:0]  b_mem_wstrb;
  logic [2:0]  b_sel;

  logic        s_req_ready, s_mem_req, s_mem_we, s_resp_valid, s_resp_err;
  logic [63:0] s_mem_addr, s_mem_wdata, s_mem_value;
  logic [7:0]  s_mem_wstrb;
  logic [2:0]  s_sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_sequencer #(.ALLOW_SPLIT(1'b1), .TIMEOUT_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(a_req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_ack(mem_ack_a), .mem_rdata(mem_rdata),
    .resp_valid(a_resp_valid), .resp_err(a_resp_err), .sel_mem_extension(a_sel),
    .mem_value(a_mem_value)
  );

  load_store_sequencer #(.ALLOW_SPLIT(1'b0), .TIMEOUT_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(b_req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_ack(mem_ack_b), .mem_rdata(mem_rdata),
    .resp_valid(b_resp_valid), .resp_err(b_resp_err), .sel_mem_extension(b_sel),
    .mem_value(b_mem_value)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit use_b);
    s_req_ready  = use_b ? b_req_ready  : a_req_ready;
    s_mem_req    = use_b ? b_mem_req    : a_mem_req;
    s_mem_we     = use_b ? b_mem_we     : a_mem_we;
    s_mem_addr   = use_b ? b_mem_addr   : a_mem_addr;
    s_mem_wdata  = use_b ? b_mem_wdata  : a_mem_wdata;
    s_mem_wstrb  = use_b ? b_mem_wstrb  : a_mem_wstrb;
    s_resp_valid = use_b ? b_resp_valid : a_resp_valid;
    s_resp_err   = use_b ? b_resp_err   : a_resp_err;
    s_sel        = use_b ? b_sel        : a_sel;
    s_mem_value  = use_b ? b_mem_value  : a_mem_value;
  endtask

  task automatic set_valid(input bit use_b, input logic v);
    if (use_b) req_valid_b = v; else req_valid_a = v;
  endtask

  task automatic set_ack(input bit use_b, input logic v);
    if (use_b) mem_ack_b = v; else mem_ack_a = v;
  endtask

  // Byte-by-byte model: each access byte i lands at absolute address addr+i.
  task automatic model(input logic st, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rd0, input logic [63:0] rd1,
                       input bit split_ok, output bit ok, output int nb,
                       output logic [63:0] ba0, output logic [63:0] ba1,
                       output logic [7:0] bs0, output logic [7:0] bs1,
                       output logic [63:0] bd0, output logic [63:0] bd1,
                       output logic [63:0] ev, output logic [2:0] es);
    int n, o;
    case (f3[1:0])
      2'd0: n = 1;
      2'd1: n = 2;
      2'd2: n = 4;
      default: n = 8;
    endcase
    o   = int'(addr[2:0]);
    nb  = (o + n > 8) ? 2 : 1;
    ok  = 1'b1;
    if (st && f3[2]) ok = 1'b0;
    if (!st && f3 == 3'b111) ok = 1'b0;
    if (nb == 2 && !split_ok) ok = 1'b0;
    ba0 = addr - 64'(o);
    ba1 = ba0 + 64'd8;
    bs0 = '0; bs1 = '0; bd0 = '0; bd1 = '0; ev = '0;
    for (int i = 0; i < n; i++) begin
      int p;
      p = o + i;
      if (p < 8) begin
        bs0[p] = 1'b1;
        bd0[p*8 +: 8] = wdata[i*8 +: 8];
        ev[i*8 +: 8]  = rd0[p*8 +: 8];
      end else begin
        bs1[p-8] = 1'b1;
        bd1[(p-8)*8 +: 8] = wdata[i*8 +: 8];
        ev[i*8 +: 8]      = rd1[(p-8)*8 +: 8];
      end
    end
    case (f3)
      3'b000:  es = 3'b000;
      3'b100:  es = 3'b001;
      3'b001:  es = 3'b010;
      3'b101:  es = 3'b011;
      3'b010:  es = 3'b100;
      3'b110:  es = 3'b101;
      3'b011:  es = 3'b110;
      default: es = 3'b000;
    endcase
    if (st) es = 3'b000;
  endtask

  // One request from accept to post-response idle; entered just after a falling edge.
  task automatic txn(input bit use_b, input logic st, input logic [2:0] f3,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] rd0, input logic [63:0] rd1, input int w0, input int w1);
    bit ok;
    int nb, w;
    logic [63:0] ba0, ba1, bd0, bd1, ev, ba, bd, dm;
    logic [7:0]  bs0, bs1, bs;
    logic [2:0]  es;
    model(st, f3, addr, wdata, rd0, rd1, !use_b, ok, nb, ba0, ba1, bs0, bs1, bd0, bd1, ev, es);
    sample(use_b);
    chk("req_ready_idle", s_req_ready, 1);
    set_valid(use_b, 1'b1);
    req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    set_valid(use_b, 1'b0);
    req_is_store = 1'($urandom_range(0, 1));
    req_funct3   = 3'($urandom_range(0, 7));
    req_addr     = {$urandom, $urandom};
    req_wdata    = {$urandom, $urandom};
    if (ok) begin
      for (int b = 0; b < nb; b++) begin
        ba = (b == 0) ? ba0 : ba1;
        bs = st ? ((b == 0) ? bs0 : bs1) : 8'h00;
        bd = (b == 0) ? bd0 : bd1;
        w  = (b == 0) ? w0 : w1;
        for (int j = 0; j < 8; j++) dm[j*8 +: 8] = {8{bs[j]}};
        for (int k = 0; k <= w; k++) begin
          sample(use_b);
          chk("mem_req", s_mem_req, 1);
          chk("mem_addr", s_mem_addr, ba);
          chk("mem_we", s_mem_we, st);
          chk("mem_wstrb", s_mem_wstrb, bs);
          if (st) chk("mem_wdata", s_mem_wdata & dm, bd);
          chk("resp_early", s_resp_valid, 0);
          chk("req_ready_busy", s_req_ready, 0);
          set_ack(use_b, k == w);
          mem_rdata = (k == w) ? ((b == 0) ? rd0 : rd1) : {$urandom, $urandom};
          @(negedge clk);
        end
        set_ack(use_b, 1'b0);
        mem_rdata = {$urandom, $urandom};
      end
    end
    sample(use_b);
    chk("resp_valid", s_resp_valid, 1);
    chk("resp_err", s_resp_err, ok ? 64'd0 : 64'd1);
    chk("resp_no_mem_req", s_mem_req, 0);
    if (ok) chk("sel_ext", s_sel, es);
    if (ok && !st) chk("mem_value", s_mem_value, ev);
    @(negedge clk);
    sample(use_b);
    chk("resp_one_cycle", s_resp_valid, 0);
    chk("req_ready_after", s_req_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0; req_is_store = 1'b0;
    req_funct3 = 3'b000; req_addr = 64'h0; req_wdata = 64'h0;
    mem_ack_a = 1'b0; mem_ack_b = 1'b0; mem_rdata = 64'h0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      sample(u == 1);
      chk("rst_req_ready", s_req_ready, 1);
      chk("rst_mem_req", s_mem_req, 0);
      chk("rst_mem_addr", s_mem_addr, 0);
      chk("rst_mem_wstrb", s_mem_wstrb, 0);
      chk("rst_resp_valid", s_resp_valid, 0);
      chk("rst_mem_value", s_mem_value, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // LW 0x1004, immediate ack
    txn(1'b0, 1'b0, 3'b010, 64'h1004, 64'h0, 64'hDEAD_BEEF_0000_0000, 64'h0, 0, 0);
    // SH 0x2007 crossing, immediate acks
    txn(1'b0, 1'b1, 3'b001, 64'h2007, 64'hABCD, 64'h0, 64'h0, 0, 0);
    // LD 0x3003, two-cycle ack delay per beat
    txn(1'b0, 1'b0, 3'b011, 64'h3003, 64'h0, 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00, 2, 2);
    // illegal load funct3
    txn(1'b0, 1'b0, 3'b111, 64'h1000, 64'h0, 64'h0, 64'h0, 0, 0);
    // illegal store funct3
    txn(1'b0, 1'b1, 3'b100, 64'h1000, 64'h55, 64'h0, 64'h0, 0, 0);
    // beat1 address wraps to zero
    txn(1'b0, 1'b0, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1, 0);
    // no-split instance: crossing LD is rejected, aligned SD works
    txn(1'b1, 1'b0, 3'b011, 64'h4001, 64'h0, 64'h0, 64'h0, 0, 0);
    txn(1'b1, 1'b1, 3'b011, 64'h6000, 64'h0F0E_0D0C_0B0A_0908, 64'h0, 64'h0, 3, 0);

    // timeout after four unacknowledged cycles
    set_valid(1'b1, 1'b1);
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 64'h5000;
    @(negedge clk);
    set_valid(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      sample(1'b1);
      chk("to_mem_req", s_mem_req, 1);
      chk("to_resp_early", s_resp_valid, 0);
      @(negedge clk);
    end
    sample(1'b1);
    chk("to_mem_req_drop", s_mem_req, 0);
    chk("to_resp_valid", s_resp_valid, 1);
    chk("to_resp_err", s_resp_err, 1);
    @(negedge clk);
    sample(1'b1);
    chk("to_ready", s_req_ready, 1);

    // reset during BEAT1 of a crossing store
    set_valid(1'b0, 1'b1);
    req_is_store = 1'b1; req_funct3 = 3'b001; req_addr = 64'h2007; req_wdata = 64'hABCD;
    @(negedge clk);
    set_valid(1'b0, 1'b0);
    mem_ack_a = 1'b1;
    @(negedge clk);
    mem_ack_a = 1'b0;
    sample(1'b0);
    chk("rb_mem_req", s_mem_req, 1);
    chk("rb_beat1_addr", s_mem_addr, 64'h2008);
    rst_n = 1'b0;
    #1;
    sample(1'b0);
    chk("rb_req_drop", s_mem_req, 0);
    chk("rb_ready", s_req_ready, 1);
    chk("rb_no_resp", s_resp_valid, 0);
    mem_ack_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack_a = 1'b0;
    sample(1'b0);
    chk("rb_late_ack_req", s_mem_req, 0);
    chk("rb_late_ack_resp", s_resp_valid, 0);
    chk("rb_late_ack_ready", s_req_ready, 1);
    @(negedge clk);
    sample(1'b0);
    chk("rb_still_quiet", s_resp_valid, 0);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      txn(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 40; i++) begin
      txn(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          int'($urandom_range(0, 3)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
